// File: rtl/uart_bpm_cmd_parser_if.sv
// Byte-in / tempo-command-out bundle between the UART receiver, the BPM parser and the metronome core.
interface uart_bpm_cmd_parser_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_busy;
    logic        o_bpm_ready;
    logic [8:0]  o_bpm;
    logic [31:0] o_bpm_count;
    logic        o_err;
    logic [1:0]  o_err_code;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_busy, o_bpm_ready, o_bpm, o_bpm_count, o_err, o_err_code
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_busy, o_bpm_ready, o_bpm, o_bpm_count, o_err, o_err_code
    );
endinterface

// File: rtl/uart_bpm_cmd_parser.sv
// Parses "B<digits><CR|LF>" frames from the UART byte stream, range-checks the BPM and
// derives the beat period (CLK_HZ*60/bpm) with a 32-step restoring divider.
module uart_bpm_cmd_parser #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BPM_MIN    = 30,
    parameter int unsigned BPM_MAX    = 300,
    parameter int unsigned MAX_DIGITS = 3
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    uart_bpm_cmd_parser_if.slave bus
);
    localparam int unsigned ACC_W   = (MAX_DIGITS * 4 > 10) ? MAX_DIGITS * 4 : 10;
    localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [31:0] DIVIDEND    = 32'(64'(CLK_HZ) * 64'd60);
    localparam logic [31:0] DEFAULT_CNT = 32'(CLK_HZ / 2);

    generate
        if (64'(CLK_HZ) * 64'd60 >= 64'h1_0000_0000) begin : g_chk_clk
            $error("CLK_HZ*60 must be below 2^32");
        end
        if (BPM_MAX > 511) begin : g_chk_bpm
            $error("BPM_MAX must not exceed 511");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        DIVIDE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] digit_cnt;
    logic [8:0]       divisor;
    logic [8:0]       rem;
    logic [31:0]      quo;
    logic [4:0]       iter;

    logic        is_b;
    logic        is_digit;
    logic        is_eol;
    logic [9:0]  rem_shift;
    logic        fits;
    logic [8:0]  rem_next;
    logic [31:0] quo_next;

    assign is_b     = (bus.i_rx_data == 8'h42) || (bus.i_rx_data == 8'h62);
    assign is_digit = (bus.i_rx_data >= 8'h30) && (bus.i_rx_data <= 8'h39);
    assign is_eol   = (bus.i_rx_data == 8'h0D) || (bus.i_rx_data == 8'h0A);

    // One restoring-division step: the dividend streams out of quo MSB first while quotient bits shift in.
    assign rem_shift = {rem, quo[31]};
    assign fits      = rem_shift >= {1'b0, divisor};
    assign rem_next  = fits ? 9'(rem_shift - {1'b0, divisor}) : rem_shift[8:0];
    assign quo_next  = {quo[30:0], fits};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            acc             <= '0;
            digit_cnt       <= '0;
            divisor         <= '0;
            rem             <= '0;
            quo             <= '0;
            iter            <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_bpm_ready <= 1'b0;
            bus.o_bpm       <= 9'd120;
            bus.o_bpm_count <= DEFAULT_CNT;
            bus.o_err       <= 1'b0;
            bus.o_err_code  <= 2'd0;
        end else begin
            bus.o_bpm_ready <= 1'b0;
            bus.o_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rx_valid && is_b) begin
                        acc       <= '0;
                        digit_cnt <= '0;
                        state     <= DIGITS;
                    end
                end
                DIGITS: begin
                    if (bus.i_rx_valid) begin
                        if (is_digit) begin
                            if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                                acc       <= ACC_W'(acc * ACC_W'(10) + ACC_W'(bus.i_rx_data[3:0]));
                                digit_cnt <= CNT_W'(digit_cnt + CNT_W'(1));
                            end else begin
                                bus.o_err      <= 1'b1;
                                bus.o_err_code <= 2'd1;
                                state          <= IDLE;
                            end
                        end else if (is_eol) begin
                            if (digit_cnt == '0) begin
                                bus.o_err      <= 1'b1;
                                bus.o_err_code <= 2'd2;
                                state          <= IDLE;
                            end else if (acc < ACC_W'(BPM_MIN) || acc > ACC_W'(BPM_MAX)) begin
                                bus.o_err      <= 1'b1;
                                bus.o_err_code <= 2'd3;
                                state          <= IDLE;
                            end else begin
                                divisor    <= acc[8:0];
                                quo        <= DIVIDEND;
                                rem        <= '0;
                                iter       <= '0;
                                bus.o_busy <= 1'b1;
                                state      <= DIVIDE;
                            end
                        end else if (is_b) begin
                            acc       <= '0;
                            digit_cnt <= '0;
                        end else begin
                            bus.o_err      <= 1'b1;
                            bus.o_err_code <= 2'd0;
                            state          <= IDLE;
                        end
                    end
                end
                DIVIDE: begin
                    // Incoming bytes are deliberately ignored here.
                    rem  <= rem_next;
                    quo  <= quo_next;
                    iter <= 5'(iter + 5'd1);
                    if (iter == 5'd31) begin
                        bus.o_bpm       <= divisor;
                        bus.o_bpm_count <= quo_next;
                        bus.o_bpm_ready <= 1'b1;
                        bus.o_busy      <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bpm_cmd_parser.sv
// Directed and randomized frames against a string-level model of the BPM command syntax.
module tb_uart_bpm_cmd_parser;
    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned BPM_MIN    = 30;
    localparam int unsigned BPM_MAX    = 300;
    localparam int unsigned MAX_DIGITS = 3;

    logic i_clk = 1'b0;
    logic i_reset_n;
    always #5 i_clk = ~i_clk;

    uart_bpm_cmd_parser_if bus();

    uart_bpm_cmd_parser #(
        .CLK_HZ    (CLK_HZ),
        .BPM_MIN   (BPM_MIN),
        .BPM_MAX   (BPM_MAX),
        .MAX_DIGITS(MAX_DIGITS)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .bus      (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int n_ready = 0;
    int n_err   = 0;
    int n_both  = 0;

    always @(negedge i_clk) begin
        if (bus.o_bpm_ready === 1'b1) n_ready++;
        if (bus.o_err === 1'b1) n_err++;
        if (bus.o_bpm_ready === 1'b1 && bus.o_err === 1'b1) n_both++;
    end

    // Reference model: frame text collected as a queue of digit values
    bit     in_frame = 1'b0;
    int     digs[$];
    int     exp_ready = 0;
    int     exp_err   = 0;
    int     exp_code  = 0;
    longint exp_bpm   = 120;
    longint exp_count = longint'(CLK_HZ) / 2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reject(input int code);
        exp_err++;
        exp_code = code;
        in_frame = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        longint v;
        if (!in_frame) begin
            if (b == 8'h42 || b == 8'h62) begin
                in_frame = 1'b1;
                digs.delete();
            end
        end else if (b >= 8'h30 && b <= 8'h39) begin
            if (digs.size() < int'(MAX_DIGITS)) digs.push_back(int'(b) - 48);
            else model_reject(1);
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (digs.size() == 0) model_reject(2);
            else begin
                v = 0;
                foreach (digs[i]) v = v * 10 + digs[i];
                if (v < BPM_MIN || v > BPM_MAX) model_reject(3);
                else begin
                    exp_ready++;
                    exp_bpm   = v;
                    exp_count = (longint'(CLK_HZ) * 60) / v;
                    in_frame  = 1'b0;
                end
            end
        end else if (b == 8'h42 || b == 8'h62) begin
            digs.delete();
        end else begin
            model_reject(0);
        end
    endtask

    task automatic model_reset();
        in_frame  = 1'b0;
        digs.delete();
        exp_code  = 0;
        exp_bpm   = 120;
        exp_count = longint'(CLK_HZ) / 2;
    endtask

    // Called #1 after a rising edge; leaves the strobe high for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(posedge i_clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input string s);
        for (int i = 0; i < s.len(); i++) begin
            model_byte(s[i]);
            send_byte(s[i]);
        end
    endtask

    task automatic settle();
        repeat (40) @(posedge i_clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ready_pulses"}, 64'(n_ready), 64'(exp_ready));
        chk({tag, "_err_pulses"}, 64'(n_err), 64'(exp_err));
        chk({tag, "_err_code"}, 64'(bus.o_err_code), 64'(exp_code));
        chk({tag, "_bpm"}, 64'(bus.o_bpm), 64'(exp_bpm));
        chk({tag, "_count"}, 64'(bus.o_bpm_count), 64'(exp_count));
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({tag, "_overlap"}, 64'(n_both), 64'd0);
    endtask

    task automatic frame(input string tag, input string s);
        send_bytes(s);
        settle();
        check_model(tag);
    endtask

    initial begin
        int busy_cycles;
        int ready_at;
        int ready_hits;
        string s;

        i_reset_n      = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_ready", 64'(bus.o_bpm_ready), 64'd0);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        chk("rst_err_code", 64'(bus.o_err_code), 64'd0);
        chk("rst_bpm", 64'(bus.o_bpm), 64'd120);
        chk("rst_count", 64'(bus.o_bpm_count), 64'd25_000_000);
        i_reset_n = 1'b1;
        repeat (100) @(posedge i_clk);
        #1;
        check_model("idle100");

        // First accepted frame: busy for exactly 32 cycles, single ready at T+33
        send_bytes("B120\015");
        busy_cycles = 0;
        ready_at    = 0;
        ready_hits  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.o_busy === 1'b1) busy_cycles++;
            if (bus.o_bpm_ready === 1'b1) begin
                ready_hits++;
                ready_at = k;
            end
            @(posedge i_clk);
            #1;
        end
        chk("b120_busy_cycles", 64'(busy_cycles), 64'd32);
        chk("b120_ready_cycle", 64'(ready_at), 64'd33);
        chk("b120_ready_hits", 64'(ready_hits), 64'd1);
        check_model("b120");
        chk("b120_count_const", 64'(bus.o_bpm_count), 64'd25_000_000);

        frame("b300", "b300\n");
        chk("b300_count_const", 64'(bus.o_bpm_count), 64'd10_000_000);
        frame("b45", "B45\015");
        chk("b45_count_const", 64'(bus.o_bpm_count), 64'd66_666_666);

        frame("e_range", "B7\015");
        chk("e_range_code", 64'(bus.o_err_code), 64'd3);
        frame("e_digits", "B1234");
        chk("e_digits_code", 64'(bus.o_err_code), 64'd1);
        frame("e_nodig", "B\n");
        chk("e_nodig_code", 64'(bus.o_err_code), 64'd2);
        frame("e_char", "B1x");
        chk("e_char_code", 64'(bus.o_err_code), 64'd0);
        frame("e_lead0", "B0301\015");
        chk("e_lead0_code", 64'(bus.o_err_code), 64'd1);
        chk("e_lead0_count_kept", 64'(bus.o_bpm_count), 64'd66_666_666);

        frame("resync", "B9B150\015");
        chk("resync_count_const", 64'(bus.o_bpm_count), 64'd20_000_000);
        frame("noise", "xyz\015\nB60\015");
        chk("noise_count_const", 64'(bus.o_bpm_count), 64'd50_000_000);

        // Bytes strobed while dividing are dropped and do not reach the model
        send_bytes("B200\015");
        chk("drop_busy", 64'(bus.o_busy), 64'd1);
        send_byte(8'h42);
        send_byte(8'h39);
        settle();
        check_model("drop");
        chk("drop_count_const", 64'(bus.o_bpm_count), 64'd15_000_000);
        frame("drop_cr", "\015");

        // Reset in the middle of a division aborts it without a pulse
        s = "B100\015";
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (8) @(posedge i_clk);
        #1;
        chk("mid_busy_before_rst", 64'(bus.o_busy), 64'd1);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("mid_rst_bpm", 64'(bus.o_bpm), 64'd120);
        chk("mid_rst_count", 64'(bus.o_bpm_count), 64'd25_000_000);
        settle();
        check_model("mid_rst");
        frame("after_rst", "B100\015");
        chk("after_rst_count_const", 64'(bus.o_bpm_count), 64'd30_000_000);

        // Randomized frames: half well-formed values, half random junk bodies
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $sformatf("%s%0d%s", ($urandom_range(0, 1) == 1) ? "B" : "b",
                              $urandom_range(BPM_MIN - 10, BPM_MAX + 10),
                              ($urandom_range(0, 1) == 1) ? "\015" : "\n");
            end else begin
                s = "B";
                for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
                    case ($urandom_range(0, 11))
                        8:       s = {s, "x"};
                        9:       s = {s, "B"};
                        10:      s = {s, "b"};
                        11:      s = {s, " "};
                        default: s = {s, $sformatf("%0d", $urandom_range(0, 9))};
                    endcase
                end
                s = {s, ($urandom_range(0, 1) == 1) ? "\015" : "\n"};
            end
            frame($sformatf("rnd%0d", f), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_bpm_cmd_parser.md
Name: uart_bpm_cmd_parser

Overview:
Converts the UART byte stream into tempo commands for the metronome. It sits between the UART byte receiver (8N1 deserialiser, one-cycle byte strobe) and the metronome core. It parses ASCII frames of the form "B<digits><CR|LF>" and range-checks the BPM value. It then computes the beat period in clock cycles with an iterative divider and issues a one-cycle ready pulse with the new count, or an error pulse.

Parameters:
CLK_HZ, 50_000_000, clock frequency of i_clk; CLK_HZ*60 must be < 2^32 (elaboration-time check)
BPM_MIN, 30, lowest accepted BPM (inclusive)
BPM_MAX, 300, highest accepted BPM (inclusive); must be ≤ 511
MAX_DIGITS, 3, maximum decimal digits per frame

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous reset, active-low
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte
i_rx_data  in  8  received byte
o_busy  out  1  high while in DIVIDE; bytes strobed while high are dropped
o_bpm_ready  out  1  one-cycle pulse: o_bpm and o_bpm_count updated
o_bpm  out  9  last accepted BPM value
o_bpm_count  out  32  clock cycles per beat = floor(CLK_HZ*60 / o_bpm)
o_err  out  1  one-cycle pulse: frame rejected
o_err_code  out  2  0 bad char, 1 too many digits, 2 no digits, 3 out of range; holds until next error

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset_n.
- Reset values (i_reset_n low at a rising edge):
  - state = IDLE; o_busy, o_bpm_ready, o_err, o_err_code = 0.
  - o_bpm = 120; o_bpm_count = CLK_HZ/2 (the 120 BPM default).
  - Internal accumulator, digit counter and divider registers cleared.
  - Reset applies in every state, including mid-DIVIDE: the result is discarded and no pulse is issued.
- States: IDLE, DIGITS, DIVIDE.
- IDLE:
  - On a byte 'B' (0x42) or 'b' (0x62): accumulator = 0, digit count = 0, go to DIGITS.
  - All other bytes are ignored silently, including a stray CR/LF.
- DIGITS, on each i_rx_valid:
  - '0'..'9': if digit count < MAX_DIGITS, acc = acc*10 + digit and count++. Otherwise pulse o_err with code 1 and go to IDLE.
  - CR (0x0D) or LF (0x0A) with count = 0: error code 2, go to IDLE.
  - CR/LF with acc < BPM_MIN or acc > BPM_MAX: error code 3, go to IDLE.
  - CR/LF otherwise: latch acc as the divisor, go to DIVIDE.
  - 'B'/'b': resync. Restart the frame (acc = 0, count = 0) and stay in DIGITS; no error.
  - Any other byte: error code 0, go to IDLE.
- Arithmetic: the accumulator is ≥10 bits wide, so 999 fits without wrap. Leading zeros count as digits.
- DIVIDE:
  - Restoring division of the constant CLK_HZ*60 (32-bit) by the 9-bit divisor, one quotient bit per cycle, MSB first, exactly 32 iterations.
  - o_busy = 1 throughout.
- Timing: terminator accepted in cycle T; iterations run in cycles T+1..T+32. In cycle T+33:
  - o_bpm and o_bpm_count carry the new values.
  - o_bpm_ready = 1 for that cycle only.
  - o_busy = 0; state = IDLE.
- Bytes in DIVIDE: i_rx_valid during DIVIDE (including a new 'B') is dropped with no error. The first byte honoured is the one strobed in T+33.
- Stability: o_bpm and o_bpm_count change only at a ready pulse or reset. Error frames never alter them.
- o_err and o_bpm_ready are never asserted in the same cycle.
- o_err asserts in the cycle after the offending byte's strobe (registered).

Test Plan:
- Release reset, no traffic → o_bpm=120, o_bpm_count=25_000_000, no pulses for 100 cycles.
- Bytes "B120\r" (CLK_HZ=50e6) → o_busy high 32 cycles; at T+33 single o_bpm_ready, o_bpm=120, o_bpm_count=25_000_000. Then "b300\n" → o_bpm_count=10_000_000. Then "B45\r" → o_bpm_count=66_666_666 (floor).
- Error frames, each producing one o_err pulse, o_bpm/o_bpm_count unchanged:
  - "B7\r" → code 3.
  - "B1234" → code 1 on the '4'.
  - "B\n" → code 2.
  - "B1x" → code 0.
  - "B0301\r" → code 1 (leading zero counts).
- Resync and noise: "B9B150\r" → accepted as 150, o_bpm_count=20_000_000. "xyz\r\nB60\r" → garbage ignored, no error, o_bpm_count=50_000_000.
- Send "B200\r", then strobe "B" and "9" during DIVIDE → both dropped, ready pulse for 200 (count 15_000_000). Subsequent "\r" in IDLE is ignored.
- Assert i_reset_n=0 for 1 cycle at T+10 of a "B100\r" divide → no ready pulse, o_bpm=120 and o_bpm_count=25_000_000 restored, state IDLE. Next "B100\r" → count 30_000_000.
